// File: rtl/imu_uart_pkt_framer.sv
// imu_uart_pkt_framer
// Pulls fixed-size IMU packets out of the UART byte stream. It hunts the
// 2-byte header, collects the rest of the packet into a local buffer and
// verifies the 8-bit checksum. Only checksum-valid packets are replayed
// toward the FIFO, header included. Bad, timed-out and overlapping traffic
// is counted and never forwarded.
//
// Output handshake: a beat transfers on a cycle where pkt_vld & pkt_rdy are
// both high. Once pkt_vld is raised, pkt_data/pkt_sof/pkt_eof hold steady
// until that transfer, and pkt_vld stays high. pkt_vld never waits on pkt_rdy.
module imu_uart_pkt_framer #(
  parameter int          IMU_PKT_SIZE   = 46,
  parameter logic [15:0] IMU_PKT_HEADER = 16'h5AA5,
  parameter int          TIMEOUT_CYC    = 20000,
  parameter int          CNT_W          = 16
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             rx_vld,
  input  logic [7:0]       rx_data,
  input  logic             pkt_rdy,
  output logic             pkt_vld,
  output logic [7:0]       pkt_data,
  output logic             pkt_sof,
  output logic             pkt_eof,
  output logic             busy,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] cks_err_cnt,
  output logic [CNT_W-1:0] tmo_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [2:0]       dbg_state
);

  // The gap timer must hold TIMEOUT_CYC+1 so the header hunt can see "> limit".
  localparam int               GAP_W    = $clog2(TIMEOUT_CYC + 2);
  localparam logic [GAP_W-1:0] GAP_TMO  = GAP_W'(TIMEOUT_CYC);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT_CYC + 1);
  localparam logic [5:0]       LAST_IDX = 6'(IMU_PKT_SIZE - 1);
  localparam logic [7:0]       HDR_HI   = IMU_PKT_HEADER[15:8];
  localparam logic [7:0]       HDR_LO   = IMU_PKT_HEADER[7:0];

  typedef enum logic [2:0] {
    HUNT_H0 = 3'd0,
    HUNT_H1 = 3'd1,
    COLLECT = 3'd2,
    CHECK   = 3'd3,
    EMIT    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       cks_q, cks_d;
  logic             pkt_vld_q, pkt_vld_d;
  logic [7:0]       pkt_data_q, pkt_data_d;
  logic             pkt_sof_q, pkt_sof_d;
  logic             pkt_eof_q, pkt_eof_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] cks_err_q, cks_err_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [7:0]       pkt_buf [IMU_PKT_SIZE];
  logic             wr_en;
  logic [5:0]       nxt_idx;
  logic [7:0]       nxt_byte;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Next-state, datapath and counter logic for the whole framer.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    sum_d      = sum_q;
    cks_d      = cks_q;
    pkt_vld_d  = pkt_vld_q;
    pkt_data_d = pkt_data_q;
    pkt_sof_d  = pkt_sof_q;
    pkt_eof_d  = pkt_eof_q;
    good_d     = good_q;
    cks_err_d  = cks_err_q;
    tmo_d      = tmo_q;
    drop_d     = drop_q;
    wr_en      = 1'b0;

    // Header bytes are never written to the buffer; slots 0/1 read as constants.
    nxt_idx = idx_q + 6'd1;
    if (nxt_idx == 6'd0)      nxt_byte = HDR_HI;
    else if (nxt_idx == 6'd1) nxt_byte = HDR_LO;
    else                      nxt_byte = pkt_buf[nxt_idx];

    case (state_q)
      HUNT_H0: begin
        if (rx_vld && rx_data == HDR_HI) begin
          state_d = HUNT_H1;
          gap_d   = '0;
        end
      end

      HUNT_H1: begin
        if (rx_vld) begin
          gap_d = '0;
          if (rx_data == HDR_LO) begin
            state_d = COLLECT;
            idx_d   = 6'd2;
            sum_d   = 8'd0;
          end else if (rx_data != HDR_HI) begin
            state_d = HUNT_H0;
          end
        end else if (gap_q > GAP_TMO) begin
          // A lone first header byte is not a packet, so this is not counted.
          state_d = HUNT_H0;
        end else if (gap_q != GAP_MAX) begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      COLLECT: begin
        // A byte arriving exactly at the limit still wins over the timeout.
        if (rx_vld) begin
          wr_en = 1'b1;
          gap_d = '0;
          if (idx_q == LAST_IDX) begin
            cks_d   = rx_data;
            state_d = CHECK;
          end else begin
            sum_d = sum_q + rx_data;
            idx_d = nxt_idx;
          end
        end else if (gap_q >= GAP_TMO) begin
          tmo_d   = sat_inc(tmo_q);
          state_d = HUNT_H0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      CHECK: begin
        if (rx_vld) drop_d = sat_inc(drop_q);
        if (sum_q == cks_q) begin
          state_d    = EMIT;
          idx_d      = 6'd0;
          pkt_vld_d  = 1'b1;
          pkt_data_d = HDR_HI;
          pkt_sof_d  = 1'b1;
          pkt_eof_d  = 1'b0;
        end else begin
          cks_err_d = sat_inc(cks_err_q);
          state_d   = HUNT_H0;
        end
      end

      EMIT: begin
        if (rx_vld) drop_d = sat_inc(drop_q);
        if (pkt_vld_q && pkt_rdy) begin
          if (idx_q == LAST_IDX) begin
            good_d     = sat_inc(good_q);
            pkt_vld_d  = 1'b0;
            pkt_data_d = 8'd0;
            pkt_sof_d  = 1'b0;
            pkt_eof_d  = 1'b0;
            state_d    = HUNT_H0;
          end else begin
            idx_d      = nxt_idx;
            pkt_data_d = nxt_byte;
            pkt_sof_d  = 1'b0;
            pkt_eof_d  = (nxt_idx == LAST_IDX);
          end
        end
      end

      default: state_d = HUNT_H0;
    endcase
  end

  // State, output and counter registers; reset drops any packet in flight.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT_H0;
      idx_q      <= '0;
      gap_q      <= '0;
      sum_q      <= '0;
      cks_q      <= '0;
      pkt_vld_q  <= 1'b0;
      pkt_data_q <= '0;
      pkt_sof_q  <= 1'b0;
      pkt_eof_q  <= 1'b0;
      good_q     <= '0;
      cks_err_q  <= '0;
      tmo_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      sum_q      <= sum_d;
      cks_q      <= cks_d;
      pkt_vld_q  <= pkt_vld_d;
      pkt_data_q <= pkt_data_d;
      pkt_sof_q  <= pkt_sof_d;
      pkt_eof_q  <= pkt_eof_d;
      good_q     <= good_d;
      cks_err_q  <= cks_err_d;
      tmo_q      <= tmo_d;
      drop_q     <= drop_d;
    end
  end

  // Packet buffer: written only in COLLECT, read only in EMIT.
  always_ff @(posedge sys_clk) begin
    if (wr_en) pkt_buf[idx_q] <= rx_data;
  end

  assign pkt_vld     = pkt_vld_q;
  assign pkt_data    = pkt_data_q;
  assign pkt_sof     = pkt_sof_q;
  assign pkt_eof     = pkt_eof_q;
  assign busy        = (state_q != HUNT_H0);
  assign good_cnt    = good_q;
  assign cks_err_cnt = cks_err_q;
  assign tmo_cnt     = tmo_q;
  assign drop_cnt    = drop_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_imu_uart_pkt_framer.sv
// Bench for imu_uart_pkt_framer: directed scenarios plus randomized packets,
// checked against a stream-level packet model and an expected-beat queue.
module tb_imu_uart_pkt_framer;

  localparam int         PKT  = 46;
  localparam int         TMO  = 200;
  localparam logic [7:0] H_HI = 8'h5A;
  localparam logic [7:0] H_LO = 8'hA5;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        rx_vld;
  logic [7:0]  rx_data;
  logic        pkt_rdy;
  logic        pkt_vld;
  logic [7:0]  pkt_data;
  logic        pkt_sof;
  logic        pkt_eof;
  logic        busy;
  logic [15:0] good_cnt, cks_err_cnt, tmo_cnt, drop_cnt;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  imu_uart_pkt_framer #(
    .IMU_PKT_SIZE(PKT), .IMU_PKT_HEADER(16'h5AA5), .TIMEOUT_CYC(TMO), .CNT_W(16)
  ) dut (
    .sys_clk(clk), .reset(reset), .rx_vld(rx_vld), .rx_data(rx_data),
    .pkt_rdy(pkt_rdy), .pkt_vld(pkt_vld), .pkt_data(pkt_data),
    .pkt_sof(pkt_sof), .pkt_eof(pkt_eof), .busy(busy),
    .good_cnt(good_cnt), .cks_err_cnt(cks_err_cnt), .tmo_cnt(tmo_cnt),
    .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];        // {sof, eof, data}
  logic [7:0] stream_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_good = 0, exp_cks = 0, exp_tmo = 0, exp_drop = 0;
  int last_rx_cyc = 0, first_vld_cyc = 0, vld_cycles = 0;
  logic first_rdy = 1'b0;
  int rdy_mode = 0;            // 0: always ready, 1: toggle, 2: random

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_good"}, 32'(good_cnt), 32'(exp_good));
    check({tag, "_cks"},  32'(cks_err_cnt), 32'(exp_cks));
    check({tag, "_tmo"},  32'(tmo_cnt), 32'(exp_tmo));
    check({tag, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called just after a rising edge; leaves just after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int idle);
    rx_data = b;
    rx_vld  = 1'b1;
    last_rx_cyc = cyc;
    step(1);
    rx_vld = 1'b0;
    step(idle);
  endtask

  task automatic send_stream(input int lo, input int hi);
    for (int i = 0; i < stream_q.size(); i++)
      send_byte(stream_q[i], (i == stream_q.size() - 1) ? 0 : int'($urandom_range(lo, hi)));
  endtask

  // Appends header + 43 payload bytes + checksum; payload 0x01 or random.
  task automatic build_pkt(input bit rand_body, input bit bad_cks);
    logic [7:0] b, s;
    s = 8'd0;
    stream_q.push_back(H_HI);
    stream_q.push_back(H_LO);
    for (int i = 0; i < PKT - 3; i++) begin
      b = rand_body ? 8'($urandom_range(0, 255)) : 8'h01;
      s = s + b;
      stream_q.push_back(b);
    end
    stream_q.push_back(bad_cks ? s + 8'd1 : s);
  endtask

  // Reference model: find the first adjacent header pair, take the next PKT
  // bytes as a packet, verify the sum of its body, then resume scanning.
  task automatic model_stream();
    int i;
    logic [7:0] s;
    i = 0;
    while (i + 1 < stream_q.size()) begin
      if (stream_q[i] == H_HI && stream_q[i+1] == H_LO) begin
        if (i + PKT > stream_q.size()) break;
        s = 8'd0;
        for (int j = 2; j < PKT - 1; j++) s = s + stream_q[i+j];
        if (s == stream_q[i+PKT-1]) begin
          for (int j = 0; j < PKT; j++)
            exp_q.push_back({(j == 0), (j == PKT - 1), stream_q[i+j]});
          exp_good++;
        end else begin
          exp_cks++;
        end
        i += PKT;
      end else begin
        i++;
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin step(1); n++; end
    check({tag, "_done"}, 32'(n < 5000), 32'd1);
    check_counters(tag);
  endtask

  // ---------------- ready driver ----------------
  initial begin
    pkt_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       pkt_rdy = 1'b1;
        1:       pkt_rdy = ~pkt_rdy;
        default: pkt_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- output monitor ----------------
  initial begin
    logic       prev_stall, prev_vld;
    logic [9:0] prev_beat, e;
    prev_stall = 1'b0;
    prev_vld   = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
        prev_vld   = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_vld",  32'(pkt_vld), 32'd1);
          check("hold_beat", 32'({pkt_sof, pkt_eof, pkt_data}), 32'(prev_beat));
        end
        if (pkt_vld) begin
          if (!prev_vld) begin
            first_vld_cyc = cyc;
            vld_cycles    = 0;
            first_rdy     = pkt_rdy;
          end
          vld_cycles++;
          check("vld_expected", 32'(exp_q.size() != 0), 32'd1);
          if (pkt_rdy && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat", 32'({pkt_sof, pkt_eof, pkt_data}), 32'(e));
          end
        end
        prev_stall = pkt_vld & ~pkt_rdy;
        prev_beat  = {pkt_sof, pkt_eof, pkt_data};
        prev_vld   = pkt_vld;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    reset   = 1'b1;
    rx_vld  = 1'b0;
    rx_data = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", 32'({pkt_vld, pkt_data, pkt_sof, pkt_eof, busy}), 32'd0);
    check_counters("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    step(2);

    // 1. clean packet, always ready, latency 2 from checksum byte
    stream_q.delete();
    build_pkt(1'b0, 1'b0);
    check("t1_cks_byte", 32'(stream_q[PKT-1]), 32'h2B);
    model_stream();
    send_stream(1, 3);
    wait_done("t1");
    check("t1_latency", 32'(first_vld_cyc - last_rx_cyc), 32'd2);
    check("t1_beats",   32'(vld_cycles), 32'd46);

    // 2. bad checksum: nothing emitted, busy drops right after CHECK
    stream_q.delete();
    build_pkt(1'b0, 1'b1);
    model_stream();
    send_stream(0, 2);
    @(negedge clk);
    check("t2_busy_check", 32'(busy), 32'd1);
    @(negedge clk);
    check("t2_busy_after", 32'(busy), 32'd0);
    wait_done("t2");

    // 3. junk 00 5A ahead of a valid packet
    stream_q.delete();
    stream_q.push_back(8'h00);
    stream_q.push_back(8'h5A);
    build_pkt(1'b1, 1'b0);
    model_stream();
    send_stream(0, 3);
    wait_done("t3");

    // Lone first header byte times out silently
    send_byte(H_HI, TMO + 5);
    @(negedge clk);
    check("h1_tmo_busy", 32'(busy), 32'd0);
    step(1);
    check_counters("h1_tmo");

    // 4. truncated after 20 bytes, then a clean packet
    stream_q.delete();
    build_pkt(1'b1, 1'b0);
    while (stream_q.size() > 20) void'(stream_q.pop_back());
    send_stream(0, 2);
    step(TMO + 10);
    exp_tmo++;
    check("t4_busy", 32'(busy), 32'd0);
    check_counters("t4_tmo");
    stream_q.delete();
    build_pkt(1'b1, 1'b0);
    model_stream();
    send_stream(0, 3);
    wait_done("t4_next");

    // Byte arriving exactly when the gap timer reaches the limit is accepted
    stream_q.delete();
    build_pkt(1'b1, 1'b0);
    model_stream();
    for (int i = 0; i < PKT; i++)
      send_byte(stream_q[i], (i == 10) ? TMO : ((i == PKT - 1) ? 0 : 1));
    wait_done("gap_eq");

    // One cycle later the packet is aborted; the 0x01 body cannot re-sync
    stream_q.delete();
    build_pkt(1'b0, 1'b0);
    for (int i = 0; i < PKT; i++)
      send_byte(stream_q[i], (i == 10) ? TMO + 1 : 1);
    exp_tmo++;
    wait_done("gap_over");

    // 5. ready toggling, three bytes dropped during EMIT
    rdy_mode = 1;
    stream_q.delete();
    build_pkt(1'b1, 1'b0);
    model_stream();
    send_stream(0, 2);
    begin
      int n;
      n = 0;
      while (!pkt_vld && n < 50) begin step(1); n++; end
      check("t5_vld_seen", 32'(pkt_vld), 32'd1);
    end
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 3);
    exp_drop += 3;
    wait_done("t5");
    check("t5_span", 32'(vld_cycles), first_rdy ? 32'd91 : 32'd92);
    rdy_mode = 0;
    step(2);

    // 6. reset in COLLECT at idx 30, then a clean packet
    stream_q.delete();
    build_pkt(1'b1, 1'b0);
    for (int i = 0; i < 30; i++) send_byte(stream_q[i], 1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_outs", 32'({pkt_vld, pkt_data, pkt_sof, pkt_eof, busy}), 32'd0);
    check("t6_rst_cnts", 32'(good_cnt | cks_err_cnt | tmo_cnt | drop_cnt), 32'd0);
    exp_q.delete();
    exp_good = 0; exp_cks = 0; exp_tmo = 0; exp_drop = 0;
    step(3);
    reset = 1'b0;
    step(2);
    stream_q.delete();
    build_pkt(1'b1, 1'b0);
    model_stream();
    send_stream(0, 3);
    wait_done("t6");
    check("t6_good", 32'(good_cnt), 32'd1);

    // Randomized packets with junk prefixes, corrupted checksums and random ready
    for (int r = 0; r < 8; r++) begin
      int nj;
      logic [7:0] jb;
      rdy_mode = int'($urandom_range(0, 2));
      stream_q.delete();
      nj = int'($urandom_range(0, 4));
      for (int k = 0; k < nj; k++) begin
        jb = 8'($urandom_range(0, 255));
        stream_q.push_back((jb == H_HI) ? 8'h00 : jb);
      end
      build_pkt(1'b1, $urandom_range(0, 3) == 0);
      model_stream();
      send_stream(0, 3);
      wait_done("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
